// File: rtl/twiddle_cmult.sv
// ---------------------------------------------------------------------------
// twiddle_cmult: aligns the stage-1 sample stream to its twiddle, complex-
// multiplies, rounds/saturates and tags frame start/last for stage 2.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module twiddle_cmult #(
  parameter int DW        = 16,
  parameter int TW_LAT    = 2,
  parameter int FRAME_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_img,
  output logic                 rot_valid,
  input  logic signed [17:0]   rot_real,
  input  logic signed [17:0]   rot_img,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_img,
  output logic                 out_sof,
  output logic                 out_last,
  output logic                 err_gap
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int PW = DW + 18;
  localparam int SW = DW + 19;
  localparam logic [CW-1:0]        LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic signed [SW-1:0] RND      = SW'(32768);
  localparam logic signed [SW-1:0] MAXV     = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV     = SW'(-(2 ** (DW - 1)));

  assign rot_valid = in_valid;

  // Frame position counter and sticky gap detector
  logic [CW-1:0] cnt_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (in_valid) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= '0;
      err_q <= 1'b1;
    end
  end

  assign err_gap = err_q;

  logic sof_d, last_d;
  assign sof_d  = in_valid && (cnt_q == '0);
  assign last_d = in_valid && (cnt_q == LAST_IDX);

  // Delay line so the sample meets the twiddle requested TW_LAT cycles ago
  logic                 a_valid, a_sof, a_last;
  logic signed [DW-1:0] a_real, a_img;

  generate
    if (TW_LAT == 0) begin : g_no_align
      assign a_valid = in_valid;
      assign a_sof   = sof_d;
      assign a_last  = last_d;
      assign a_real  = in_real;
      assign a_img   = in_img;
    end else begin : g_align
      logic                 dv_q [TW_LAT];
      logic                 ds_q [TW_LAT];
      logic                 dl_q [TW_LAT];
      logic signed [DW-1:0] dr_q [TW_LAT];
      logic signed [DW-1:0] di_q [TW_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < TW_LAT; i++) begin
            dv_q[i] <= 1'b0;
            ds_q[i] <= 1'b0;
            dl_q[i] <= 1'b0;
            dr_q[i] <= '0;
            di_q[i] <= '0;
          end
        end else begin
          dv_q[0] <= in_valid;
          ds_q[0] <= sof_d;
          dl_q[0] <= last_d;
          dr_q[0] <= in_real;
          di_q[0] <= in_img;
          for (int i = 1; i < TW_LAT; i++) begin
            dv_q[i] <= dv_q[i-1];
            ds_q[i] <= ds_q[i-1];
            dl_q[i] <= dl_q[i-1];
            dr_q[i] <= dr_q[i-1];
            di_q[i] <= di_q[i-1];
          end
        end
      end

      assign a_valid = dv_q[TW_LAT-1];
      assign a_sof   = ds_q[TW_LAT-1];
      assign a_last  = dl_q[TW_LAT-1];
      assign a_real  = dr_q[TW_LAT-1];
      assign a_img   = di_q[TW_LAT-1];
    end
  endgenerate

  // S1 partial products, S2 sums
  logic                 s1_v_q, s1_sof_q, s1_last_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic                 s2_v_q, s2_sof_q, s2_last_q;
  logic signed [SW-1:0] re_q, im_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_last_q <= 1'b0;
      p_rr_q    <= '0;
      p_ii_q    <= '0;
      p_ri_q    <= '0;
      p_ir_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_sof_q  <= 1'b0;
      s2_last_q <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      s1_v_q    <= a_valid;
      s1_sof_q  <= a_sof;
      s1_last_q <= a_last;
      p_rr_q    <= PW'(a_real) * PW'(rot_real);
      p_ii_q    <= PW'(a_img)  * PW'(rot_img);
      p_ri_q    <= PW'(a_real) * PW'(rot_img);
      p_ir_q    <= PW'(a_img)  * PW'(rot_real);
      s2_v_q    <= s1_v_q;
      s2_sof_q  <= s1_sof_q;
      s2_last_q <= s1_last_q;
      re_q      <= SW'(p_rr_q) - SW'(p_ii_q);
      im_q      <= SW'(p_ri_q) + SW'(p_ir_q);
    end
  end

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = x;
    if (x > MAXV)      r = MAXV;
    else if (x < MINV) r = MINV;
    return r[DW-1:0];
  endfunction

  // Round half toward +inf before dropping the 16 twiddle fraction bits
  logic signed [SW-1:0] re_rnd_d, im_rnd_d;
  assign re_rnd_d = (re_q + RND) >>> 16;
  assign im_rnd_d = (im_q + RND) >>> 16;

  logic                 ov_q, os_q, ol_q;
  logic signed [DW-1:0] or_q, oi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      os_q <= 1'b0;
      ol_q <= 1'b0;
      or_q <= '0;
      oi_q <= '0;
    end else begin
      ov_q <= s2_v_q;
      os_q <= s2_v_q && s2_sof_q;
      ol_q <= s2_v_q && s2_last_q;
      if (s2_v_q) begin
        or_q <= sat(re_rnd_d);
        oi_q <= sat(im_rnd_d);
      end
    end
  end

  assign out_valid = ov_q;
  assign out_sof   = os_q;
  assign out_last  = ol_q;
  assign out_real  = or_q;
  assign out_img   = oi_q;

endmodule

`default_nettype wire

// File: doc/twiddle_cmult.md
Name: twiddle_cmult

Overview:
- Inter-stage twiddle multiplier for the 16x16 FFT decomposition.
- Consumes the complex sample stream leaving the first radix-16 stage, drives rot_valid to the twiddle generator and receives the generator's 18-bit twiddle pair.
- Aligns data to twiddle latency, complex-multiplies, rounds and saturates.
- Emits a framed stream with start/last markers to the second radix-16 stage.

Parameters:
- DW, 16, signed width of each data component in and out.
- TW_LAT, 2, cycles from a sample's in_valid to its twiddle appearing on rot_real/rot_img.
- FRAME_LEN, 16, samples per frame; a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid; must be contiguous within a frame.
- in_real  in  DW  input real part, signed.
- in_img  in  DW  input imaginary part, signed.
- rot_valid  out  1  request to twiddle generator; combinational copy of in_valid.
- rot_real  in  18  twiddle real part, signed Q2.16 (1.0 = 65536).
- rot_img  in  18  twiddle imaginary part, signed Q2.16.
- out_valid  out  1  output sample valid.
- out_real  out  DW  product real part, signed.
- out_img  out  DW  product imaginary part, signed.
- out_sof  out  1  first sample of a frame; qualified by out_valid.
- out_last  out  1  last sample of a frame (FRAME_LEN-th); qualified by out_valid.
- err_gap  out  1  sticky flag: in_valid dropped mid-frame.

Behaviour:
- Reset: all pipeline valids, out_valid, out_sof, out_last, err_gap, out_real, out_img and the sample counter are 0. No sample in flight survives reset.
- rot_valid = in_valid (no register). The generator advances one twiddle per valid cycle and restarts at index 0 when valid drops.
- Alignment: in_real, in_img, in_valid and sof/last tags pass through a TW_LAT-deep delay line. The delayed sample is paired with rot_real/rot_img present in the same cycle.
- Pipeline after alignment, one register each:
  - S1: four signed products ar*br, ai*bi, ar*bi, ai*br, each DW+18 bits.
  - S2: re = ar*br - ai*bi; im = ar*bi + ai*br; each DW+19 bits, no overflow.
  - S3: add 2^15, arithmetic shift right 16 (round half toward +inf), then saturate to [-2^(DW-1), 2^(DW-1)-1].
- Total latency: in_valid to out_valid is TW_LAT+3 = 5 cycles at defaults. Throughput is 1 sample/cycle. No backpressure.
- out_real/out_img hold their last value when out_valid=0.
- Sample counter cnt (log2 FRAME_LEN bits), advanced on in_valid:
  - sof tag = (cnt==0); last tag = (cnt==FRAME_LEN-1).
  - On in_valid, cnt increments and wraps FRAME_LEN-1 -> 0, so back-to-back frames are allowed.
- Gap: in_valid=0 with cnt!=0 sets err_gap (sticky until rst) and clears cnt to 0. The partial frame still drains with no out_last. The next sample carries sof.
- in_valid=0 with cnt==0 is an idle cycle and does not set err_gap.
- Reset mid-operation clears all pipeline stages in the same edge. Outputs are quiet from the next cycle.

Test Plan:
- Identity: twiddle (65536,0), in (1000,-2000) on a 16-sample burst -> out (1000,-2000) 5 cycles later; out_sof on sample 0, out_last on sample 15.
- Rotate by j: twiddle (0,65536), in (300,700) -> out (-700,300).
- Rounding: twiddle (32768,0); in (1,0) -> (1,0); in (-1,0) -> (0,0); in (3,0) -> (2,0).
- Saturation: twiddle (0,65536), in (-32768,-32768) -> out (32767,-32768).
- Back-to-back frames: 32 contiguous valid samples -> out_last at output samples 15 and 31, out_sof at 0 and 16, err_gap stays 0.
- Gap and reset: drop in_valid after 5 samples -> err_gap=1, no out_last, next sample tagged sof. Then assert rst mid-burst -> out_valid=0 from the following cycle, err_gap=0.
